// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: lane/timing defaults, receiver-detect state encodings
// and width helpers used by the detect sequencer and its arbiter.
package ltssm_pkg;

    localparam int LANE_NUM_DEF    = 4;
    localparam int SETTLE_CYC_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 64;

    localparam logic [1:0] RXD_IDLE   = 2'd0;
    localparam logic [1:0] RXD_CHARGE = 2'd1;
    localparam logic [1:0] RXD_SENSE  = 2'd2;
    localparam logic [1:0] RXD_DONE   = 2'd3;

    // Lane index width; a single-lane build still carries a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int s, input int t);
        return $clog2(((s > t) ? s : t) + 1);
    endfunction

endpackage

// File: rtl/rx_det_sequencer_arbiter.sv
// Combinational round-robin arbiter: picks the first pending lane at or after
// i_ptr (wrapping) and reports it both one-hot and as an index.
module rr_arbiter
    import ltssm_pkg::*;
#(
    parameter int LANE_NUM = LANE_NUM_DEF,
    localparam int LW      = idx_width(LANE_NUM)
) (
    input  logic [LANE_NUM-1:0] i_pending,
    input  logic [LW-1:0]       i_ptr,
    output logic [LANE_NUM-1:0] o_grant,
    output logic [LW-1:0]       o_grant_idx,
    output logic                o_any
);

    // Walk from the farthest offset back to i_ptr so the nearest pending lane wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        for (int k = LANE_NUM - 1; k >= 0; k--) begin
            int j;
            j = (int'(i_ptr) + k) % LANE_NUM;
            if (i_pending[j]) begin
                o_grant     = '0;
                o_grant[j]  = 1'b1;
                o_grant_idx = LW'(j);
            end
        end
    end

    assign o_any = |i_pending;

endmodule

// File: rtl/rx_det_sequencer.sv
// Serialises per-lane receiver-detect requests onto one shared PHY detect engine,
// sequencing charge/settle/sense and returning per-lane ack and presence.
module rx_det_sequencer
    import ltssm_pkg::*;
#(
    parameter int LANE_NUM    = LANE_NUM_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int LW         = idx_width(LANE_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANE_NUM-1:0] rx_det_seq_req,
    output logic [LANE_NUM-1:0] rx_det_seq_ack,
    output logic [LANE_NUM-1:0] rx_det_valid,
    output logic [LW-1:0]       det_lane,
    output logic                det_start,
    input  logic                det_done,
    input  logic                det_present,
    output logic                det_timeout,
    output logic                busy
);

    localparam int              CW           = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
    localparam logic [CW-1:0]   SETTLE_LOAD  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]   TIMEOUT_LOAD = CW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0]   LAST_LANE    = LW'(LANE_NUM - 1);

    logic [1:0]          r_state;
    logic [LW-1:0]       r_rr_ptr;
    logic [LW-1:0]       r_det_lane;
    logic [LANE_NUM-1:0] r_grant_oh;
    logic [CW-1:0]       r_cnt;
    logic                r_det_start;
    logic                r_det_timeout;
    logic                r_result;
    logic [LANE_NUM-1:0] r_ack;
    logic [LANE_NUM-1:0] r_valid;

    logic [LANE_NUM-1:0] w_pending;
    logic [LANE_NUM-1:0] w_grant;
    logic [LW-1:0]       w_grant_idx;
    logic                w_any;
    logic                w_in_done;
    logic [LANE_NUM-1:0] w_set;
    logic [LANE_NUM-1:0] w_ack_next;
    logic [LANE_NUM-1:0] w_valid_next;

    // Acked lanes stay out of arbitration until their request drops.
    assign w_pending = rx_det_seq_req & ~r_ack;
    assign w_in_done = (r_state == RXD_DONE);

    rr_arbiter #(
        .LANE_NUM   (LANE_NUM)
    ) u_arb (
        .i_pending  (w_pending),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_idx(w_grant_idx),
        .o_any      (w_any)
    );

    // A result is only delivered if the granted lane still wants it in DONE.
    genvar gi;
    generate
        for (gi = 0; gi < LANE_NUM; gi++) begin : g_lane
            assign w_set[gi]        = w_in_done & r_grant_oh[gi] & rx_det_seq_req[gi];
            assign w_ack_next[gi]   = w_set[gi] | (r_ack[gi] & rx_det_seq_req[gi]);
            assign w_valid_next[gi] = w_set[gi] ? r_result : (r_valid[gi] & rx_det_seq_req[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= '0;
            r_valid <= '0;
        end else begin
            r_ack   <= w_ack_next;
            r_valid <= w_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RXD_IDLE;
            r_rr_ptr      <= '0;
            r_det_lane    <= '0;
            r_grant_oh    <= '0;
            r_cnt         <= '0;
            r_det_start   <= 1'b0;
            r_det_timeout <= 1'b0;
            r_result      <= 1'b0;
        end else begin
            r_det_start   <= 1'b0;
            r_det_timeout <= 1'b0;
            case (r_state)
                RXD_IDLE: begin
                    if (w_any) begin
                        r_det_lane <= w_grant_idx;
                        r_grant_oh <= w_grant;
                        r_cnt      <= SETTLE_LOAD;
                        r_state    <= RXD_CHARGE;
                    end
                end
                RXD_CHARGE: begin
                    if (r_cnt == '0) begin
                        r_det_start <= 1'b1;
                        r_cnt       <= TIMEOUT_LOAD;
                        r_state     <= RXD_SENSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RXD_SENSE: begin
                    // An engine strobe on the final sense cycle still counts as a result.
                    if (det_done) begin
                        r_result <= det_present;
                        r_state  <= RXD_DONE;
                    end else if (r_cnt == '0) begin
                        r_det_timeout <= 1'b1;
                        r_result      <= 1'b0;
                        r_state       <= RXD_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RXD_DONE: begin
                    r_rr_ptr <= (r_det_lane == LAST_LANE) ? '0 : r_det_lane + 1'b1;
                    r_state  <= RXD_IDLE;
                end
                default: r_state <= RXD_IDLE;
            endcase
        end
    end

    assign rx_det_seq_ack = r_ack;
    assign rx_det_valid   = r_valid;
    assign det_lane       = r_det_lane;
    assign det_start      = r_det_start;
    assign det_timeout    = r_det_timeout;
    assign busy           = (r_state != RXD_IDLE);

endmodule
